// File: rtl/window_mac_engine_if.sv
// Handshake and data bundle between the process FSM and the window MAC engine.
// Window and kernel taps are packed row-major, tap k occupying bits [8k+7:8k].
interface window_mac_engine_if #(
  parameter int FILTER_SIZE = 3
);
  localparam int N = FILTER_SIZE * FILTER_SIZE;

  logic                 mult_en;
  logic [N*8-1:0]       window_in;
  logic [N*8-1:0]       filter_flat;
  logic signed [31:0]   result;
  logic                 result_valid;
  logic                 shift_buffer;

  modport master (
    output mult_en, window_in, filter_flat,
    input  result, result_valid, shift_buffer
  );

  modport slave (
    input  mult_en, window_in, filter_flat,
    output result, result_valid, shift_buffer
  );
endinterface

// File: rtl/window_mac_engine.sv
// One convolution output per request: products registered on the accept edge,
// summed on the next edge, result held until the requester drops mult_en.
module window_mac_engine #(
  parameter int IMAGE_HEIGHT = 128,
  parameter int IMAGE_WIDTH  = 128,
  parameter int FILTER_SIZE  = 3,
  parameter int OUT          = IMAGE_HEIGHT - FILTER_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  window_mac_engine_if.slave   bus
);

  localparam int N      = FILTER_SIZE * FILTER_SIZE;
  localparam int PROD_W = 17;
  localparam int SUM_W  = 24;

  if (FILTER_SIZE < 1 || FILTER_SIZE > 15 || IMAGE_WIDTH < FILTER_SIZE ||
      OUT != IMAGE_HEIGHT - FILTER_SIZE + 1) begin : g_param_check
    $error("window_mac_engine: unsupported geometry parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_HOLD
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [PROD_W-1:0]  r_prod [N];
  logic signed [PROD_W-1:0]  w_prod [N];
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [31:0]        r_result;
  logic                      r_result_valid;
  logic                      r_shift_buffer;

  // Pixel is zero-extended to 9 bits so an unsigned 255 times a signed tap stays exact.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_prod[k] = $signed({9'd0, bus.window_in[8*k +: 8]}) *
                  $signed({{9{bus.filter_flat[8*k+7]}}, bus.filter_flat[8*k +: 8]});
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = w_sum + {{(SUM_W-PROD_W){r_prod[k][PROD_W-1]}}, r_prod[k]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.mult_en) w_next = S_MULT;
      S_MULT:  w_next = S_HOLD;
      S_HOLD:  if (!bus.mult_en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_shift_buffer <= 1'b0;
      for (int k = 0; k < N; k++) r_prod[k] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.mult_en) begin
            for (int k = 0; k < N; k++) r_prod[k] <= w_prod[k];
          end
        end
        S_MULT: begin
          r_result       <= {{(32-SUM_W){w_sum[SUM_W-1]}}, w_sum};
          r_result_valid <= 1'b1;
          r_shift_buffer <= 1'b1;
        end
        S_HOLD: begin
          r_shift_buffer <= 1'b0;
          if (!bus.mult_en) r_result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.shift_buffer = r_shift_buffer;

endmodule

// File: tb/tb_window_mac_engine.sv
// Directed bench for window_mac_engine: hand-computed convolution sums and
// handshake timing around request, hold, early release and mid-flight reset.
module tb_window_mac_engine;

  localparam int FS = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  window_mac_engine_if #(.FILTER_SIZE(FS)) bus ();

  window_mac_engine #(
    .IMAGE_HEIGHT(128),
    .IMAGE_WIDTH (128),
    .FILTER_SIZE (FS)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request with mult_en dropped during MULT: valid lasts exactly one cycle.
  task automatic run_req(input string tag, input logic [71:0] win,
                         input logic [71:0] flt, input logic [31:0] exp);
    bus.window_in   = win;
    bus.filter_flat = flt;
    bus.mult_en     = 1'b1;
    tick();
    check({tag, "_e0_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_e0_shift"}, 32'(bus.shift_buffer), 32'd0);
    bus.mult_en = 1'b0;
    tick();
    check({tag, "_result"},   bus.result,             exp);
    check({tag, "_e1_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_e1_shift"}, 32'(bus.shift_buffer), 32'd1);
    tick();
    check({tag, "_e2_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_e2_shift"}, 32'(bus.shift_buffer), 32'd0);
    check({tag, "_e2_hold"},  bus.result,             exp);
  endtask

  initial begin
    int pulses;
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b0;
    bus.mult_en     = 1'b0;
    bus.window_in   = '0;
    bus.filter_flat = '0;

    tick();
    tick();
    check("rst_result", bus.result,             32'd0);
    check("rst_valid",  32'(bus.result_valid), 32'd0);
    check("rst_shift",  32'(bus.shift_buffer), 32'd0);
    rst = 1'b1;
    tick();

    run_req("ones",     72'h010101010101010101, 72'h010101010101010101, 32'd9);
    run_req("maxneg",   72'hFFFFFFFFFFFFFFFFFF, 72'h808080808080808080, 32'hFFFB8480);
    run_req("onehot4",  72'h090807060504030201, 72'h000000000100000000, 32'd5);
    run_req("onehot0",  72'h090807060504030201, 72'h000000000000000001, 32'd1);
    run_req("lapl_flat", 72'h5A50463C32281E140A, 72'h00FF00FF04FF00FF00, 32'd0);
    run_req("lapl_ctr",  72'h5A50463C3C281E140A, 72'h00FF00FF04FF00FF00, 32'd40);

    // Held request; inputs change after the accept edge and must not matter.
    bus.window_in   = 72'h010101010101010101;
    bus.filter_flat = 72'h010101010101010101;
    bus.mult_en     = 1'b1;
    pulses          = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        bus.window_in   = '0;
        bus.filter_flat = 72'h808080808080808080;
      end
      if (bus.shift_buffer) pulses++;
      check($sformatf("held_valid_%0d", i), 32'(bus.result_valid), (i >= 1) ? 32'd1 : 32'd0);
    end
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_result", bus.result,   32'd9);
    bus.mult_en = 1'b0;
    tick();
    check("held_release_valid", 32'(bus.result_valid), 32'd0);

    bus.window_in   = 72'h5A50463C3C281E140A;
    bus.filter_flat = 72'h00FF00FF04FF00FF00;
    bus.mult_en     = 1'b1;
    pulses          = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.shift_buffer) pulses++;
    end
    check("second_pulses", 32'(pulses),           32'd1);
    check("second_result", bus.result,             32'd40);
    check("second_valid",  32'(bus.result_valid), 32'd1);
    bus.mult_en = 1'b0;
    tick();
    tick();

    // Reset lands while the request sits in MULT.
    bus.window_in   = 72'h090807060504030201;
    bus.filter_flat = 72'h000000000100000000;
    bus.mult_en     = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_result", bus.result,             32'd0);
    check("abort_valid",  32'(bus.result_valid), 32'd0);
    check("abort_shift",  32'(bus.shift_buffer), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.shift_buffer) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    rst = 1'b1;
    tick();
    check("restart_e0_valid", 32'(bus.result_valid), 32'd0);
    tick();
    check("restart_result", bus.result,             32'd5);
    check("restart_valid",  32'(bus.result_valid), 32'd1);
    check("restart_shift",  32'(bus.shift_buffer), 32'd1);
    bus.mult_en = 1'b0;
    tick();
    check("restart_release", 32'(bus.result_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
